sr_pulse_driver: RTL and testbench

- Drives an active-low set/reset latch interface from a noisy, asynchronous level input.
- Synchronises and debounces `level_in`, then issues exactly one active-low `set_n` pulse per debounced rising edge and one active-low `reset_n` pulse per debounced falling edge.
- Sits between external switch/pin inputs and latch-based state storage. It is the writer side of the S/R latch interface.

---
 rtl/sr_drv_pkg.sv | 23 ++
 rtl/sync2.sv | 23 ++
 rtl/sr_pulse_driver.sv | 133 +++++++++++++
 tb/tb_sr_pulse_driver.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_drv_pkg.sv
// Shared types and helpers for the S/R latch pulse driver.
package sr_drv_pkg;

  typedef enum logic [2:0] {
    StLow,
    StChkHigh,
    StPulseSet,
    StHigh,
    StChkLow,
    StPulseRst
  } sr_state_e;

  // Latch control inputs are active-low.
  localparam logic SR_ASSERTED = 1'b0;

  function automatic int unsigned cnt_width(input int unsigned debounce,
                                            input int unsigned pulse);
    int unsigned m;
    m = (debounce > pulse) ? debounce : pulse;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous single-bit inputs.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/sr_pulse_driver.sv
// Debounces a raw level and emits one active-low set/reset pulse per accepted edge.
module sr_pulse_driver
  import sr_drv_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned PULSE_CYCLES    = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic level_in,
  output logic set_n,
  output logic reset_n,
  output logic level_out,
  output logic busy
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES, PULSE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] PUL_LAST = CNT_W'(PULSE_CYCLES);

  logic             level_s;
  sr_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             set_n_q, set_n_d;
  logic             reset_n_q, reset_n_d;
  logic             level_out_q, level_out_d;
  logic             busy_q, busy_d;

  sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (level_in),
    .q     (level_s)
  );

  assign cnt_inc = cnt_q + CNT_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StLow;
      cnt_q       <= '0;
      set_n_q     <= ~SR_ASSERTED;
      reset_n_q   <= ~SR_ASSERTED;
      level_out_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      set_n_q     <= set_n_d;
      reset_n_q   <= reset_n_d;
      level_out_q <= level_out_d;
      busy_q      <= busy_d;
    end
  end

  // cnt holds samples seen in CHK states and cycles elapsed in PULSE states.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StLow: begin
        if (level_s) begin
          state_d = (DEBOUNCE_CYCLES == 1) ? StPulseSet : StChkHigh;
          cnt_d   = (DEBOUNCE_CYCLES == 1) ? '0 : CNT_ONE;
        end
      end
      StChkHigh: begin
        if (!level_s) begin
          state_d = StLow;
          cnt_d   = '0;
        end else if (cnt_inc == DEB_LAST) begin
          state_d = StPulseSet;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StPulseSet: begin
        if (cnt_inc == PUL_LAST) begin
          state_d = StHigh;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StHigh: begin
        if (!level_s) begin
          state_d = (DEBOUNCE_CYCLES == 1) ? StPulseRst : StChkLow;
          cnt_d   = (DEBOUNCE_CYCLES == 1) ? '0 : CNT_ONE;
        end
      end
      StChkLow: begin
        if (level_s) begin
          state_d = StHigh;
          cnt_d   = '0;
        end else if (cnt_inc == DEB_LAST) begin
          state_d = StPulseRst;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StPulseRst: begin
        if (cnt_inc == PUL_LAST) begin
          state_d = StLow;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = StLow;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decode the next state so they change on the same edge as the state.
  always_comb begin
    set_n_d     = (state_d == StPulseSet) ? SR_ASSERTED : ~SR_ASSERTED;
    reset_n_d   = (state_d == StPulseRst) ? SR_ASSERTED : ~SR_ASSERTED;
    level_out_d = (state_d == StPulseSet) || (state_d == StHigh) || (state_d == StChkLow);
    busy_d      = (state_d == StChkHigh) || (state_d == StPulseSet) ||
                  (state_d == StChkLow)  || (state_d == StPulseRst);
  end

  assign set_n     = set_n_q;
  assign reset_n   = reset_n_q;
  assign level_out = level_out_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sr_pulse_driver.sv
// Randomised and directed checks of sr_pulse_driver against a run-length reference model.
module tb_sr_pulse_driver;

  localparam int unsigned D = 4;
  localparam int unsigned P = 2;

  logic clk;
  logic rst_n;
  logic level_in;
  logic set_n, reset_n, level_out, busy;
  logic [3:0] obs;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: committed level, remaining pulse cycles, run of differing samples.
  logic m_s1, m_s2, m_lvl;
  int   m_left, m_run;

  sr_pulse_driver #(
    .DEBOUNCE_CYCLES (D),
    .PULSE_CYCLES    (P)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .level_in  (level_in),
    .set_n     (set_n),
    .reset_n   (reset_n),
    .level_out (level_out),
    .busy      (busy)
  );

  assign obs = {set_n, reset_n, level_out, busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_s1 = 1'b0; m_s2 = 1'b0; m_lvl = 1'b0; m_left = 0; m_run = 0;
  endtask

  task automatic model_edge(input logic lin);
    logic ls;
    if (!rst_n) begin
      model_reset();
    end else begin
      ls   = m_s2;
      m_s2 = m_s1;
      m_s1 = lin;
      if (m_left > 0) begin
        m_left--;
        m_run = 0;
      end else if (ls != m_lvl) begin
        m_run++;
        if (m_run == D) begin
          m_lvl  = ls;
          m_left = P;
          m_run  = 0;
        end
      end else begin
        m_run = 0;
      end
    end
  endtask

  function automatic logic [3:0] model_out();
    logic pulsing;
    pulsing = (m_left > 0);
    return {!(pulsing && m_lvl), !(pulsing && !m_lvl), m_lvl, pulsing || (m_run > 0)};
  endfunction

  // Drive level_in away from the edge, take one edge, update the model, settle 1ns.
  task automatic tick(input logic lin);
    level_in = lin;
    @(posedge clk);
    model_edge(lin);
    #1;
  endtask

  task automatic test_reset();
    logic lin;
    for (int i = 0; i < 6; i++) begin
      lin = 1'($urandom_range(0, 1));
      tick(lin);
      n_checks++;
      if (obs !== 4'b1100) begin
        n_fail++;
        $display("FAIL reset_state cyc %0d: got %b expected 1100", i, obs);
      end
    end
    level_in = 1'b0;
    tick(1'b0);
    tick(1'b0);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_glitch();
    int busy_cnt = 0;
    for (int e = 1; e <= 10; e++) begin
      tick((e <= 2) ? 1'b1 : 1'b0);
      if (busy === 1'b1) busy_cnt++;
      n_checks++;
      if (set_n !== 1'b1 || level_out !== 1'b0) begin
        n_fail++;
        $display("FAIL glitch edge %0d: set_n=%b level_out=%b expected 1 0", e, set_n, level_out);
      end
      n_checks++;
      if (obs !== model_out()) begin
        n_fail++;
        $display("FAIL glitch_model edge %0d: got %b expected %b", e, obs, model_out());
      end
    end
    n_checks++;
    if (busy_cnt != 2) begin
      n_fail++;
      $display("FAIL glitch_busy_len: got %0d expected 2", busy_cnt);
    end
  endtask

  task automatic test_clean_rise();
    logic exp_set;
    for (int e = 1; e <= 12; e++) begin
      tick(1'b1);
      exp_set = (e == 6 || e == 7) ? 1'b0 : 1'b1;
      n_checks++;
      if (set_n !== exp_set || reset_n !== 1'b1) begin
        n_fail++;
        $display("FAIL rise_pulse edge %0d: set_n=%b reset_n=%b expected %b 1",
                 e, set_n, reset_n, exp_set);
      end
      n_checks++;
      if (level_out !== (e >= 6) || busy !== (e >= 3 && e <= 7)) begin
        n_fail++;
        $display("FAIL rise_level_busy edge %0d: got %b%b expected %b%b",
                 e, level_out, busy, (e >= 6), (e >= 3 && e <= 7));
      end
    end
  endtask

  task automatic test_clean_fall();
    logic exp_rst;
    for (int e = 1; e <= 12; e++) begin
      tick(1'b0);
      exp_rst = (e == 6 || e == 7) ? 1'b0 : 1'b1;
      n_checks++;
      if (reset_n !== exp_rst || set_n !== 1'b1) begin
        n_fail++;
        $display("FAIL fall_pulse edge %0d: reset_n=%b set_n=%b expected %b 1",
                 e, reset_n, set_n, exp_rst);
      end
      n_checks++;
      if (level_out !== (e < 6)) begin
        n_fail++;
        $display("FAIL fall_level edge %0d: got %b expected %b", e, level_out, (e < 6));
      end
    end
  endtask

  task automatic test_toggle_in_pulse();
    int set_low = 0, rst_low = 0, first_rst = 0;
    for (int e = 1; e <= 18; e++) begin
      tick((e <= 6) ? 1'b1 : 1'b0);
      if (set_n === 1'b0) set_low++;
      if (reset_n === 1'b0) begin
        rst_low++;
        if (first_rst == 0) first_rst = e;
      end
      if (e == 8) begin
        n_checks++;
        if (level_out !== 1'b1 || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL toggle_high_state: level_out=%b busy=%b expected 1 0", level_out, busy);
        end
      end
      n_checks++;
      if (obs !== model_out()) begin
        n_fail++;
        $display("FAIL toggle_model edge %0d: got %b expected %b", e, obs, model_out());
      end
    end
    n_checks++;
    if (set_low != 2 || rst_low != 2 || first_rst != 12) begin
      n_fail++;
      $display("FAIL toggle_pulses: set_low=%0d rst_low=%0d first_rst=%0d expected 2 2 12",
               set_low, rst_low, first_rst);
    end
  endtask

  task automatic test_reset_mid_pulse();
    for (int e = 1; e <= 7; e++) tick(1'b1);
    n_checks++;
    if (set_n !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_pre: set_n=%b expected 0", set_n);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== 4'b1100) begin
      n_fail++;
      $display("FAIL midrst_async: got %b expected 1100", obs);
    end
    tick(1'b1);
    tick(1'b1);
    rst_n = 1'b1;
    model_reset();
    for (int e = 1; e <= 10; e++) begin
      tick(1'b1);
      n_checks++;
      if (set_n !== ((e == 6 || e == 7) ? 1'b0 : 1'b1) || obs !== model_out()) begin
        n_fail++;
        $display("FAIL midrst_repeat edge %0d: got %b expected %b", e, obs, model_out());
      end
    end
  endtask

  task automatic test_random();
    logic lin = level_in;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) lin = ~lin;
      tick(lin);
      n_checks++;
      if (obs !== model_out()) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %b expected %b", i, obs, model_out());
      end
      n_checks++;
      if (set_n === 1'b0 && reset_n === 1'b0) begin
        n_fail++;
        $display("FAIL random_exclusive cyc %0d: set_n=0 reset_n=0 expected not both 0", i);
      end
    end
  endtask

  initial begin
    rst_n    = 1'b1;
    level_in = 1'b0;
    model_reset();
    #1;
    rst_n = 1'b0;
    #1;
    test_reset();
    test_glitch();
    test_clean_rise();
    test_clean_fall();
    test_toggle_in_pulse();
    test_reset_mid_pulse();
    test_clean_fall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
